rst_seq_ctrl: RTL

- Reset sequencer for the flop-based datapath blocks. Drives one active-high reset per downstream stage.
- All stage resets assert immediately on the asynchronous input reset. Release is synchronous, one stage at a time, with a programmable gap between stages.
- A software-requested re-reset replays the same sequence. The block sits at the top of each clock domain and feeds the reset pins of the downstream registers.

---
 rtl/rst_seq_ctrl_pkg.sv | 25 ++
 rtl/rst_seq_ctrl_if.sv | 22 ++
 rtl/rst_seq_ctrl_sync.sv | 29 ++
 rtl/rst_seq_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl_pkg
// Shared types and constants for the reset sequencer.
//   state_t       : sequencer FSM states
//   DEF_*         : default parameter values
//   RST_VEC_ONES  : all-ones reset vector, sliced to N_STAGES by users
// ----------------------------------------------------------------------------
package rst_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int DEF_N_STAGES    = 4;
  localparam int DEF_DLY_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Widest reset vector supported; users slice the low N_STAGES bits.
  localparam int MAX_STAGES = 64;
  localparam logic [MAX_STAGES-1:0] RST_VEC_ONES = '1;

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl_if
// Control/status bundle of the reset sequencer.
//   i_soft_rst : re-reset request (master -> sequencer)
//   i_dly      : per-stage gap value D (master -> sequencer)
//   o_rst      : per-stage active-high resets (sequencer -> master)
//   o_done     : all stages released (sequencer -> master)
// ----------------------------------------------------------------------------
interface rst_seq_ctrl_if
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int DLY_W    = DEF_DLY_W
);
  logic                i_soft_rst;
  logic [DLY_W-1:0]    i_dly;
  logic [N_STAGES-1:0] o_rst;
  logic                o_done;

  modport master (output i_soft_rst, i_dly, input  o_rst, o_done);
  modport slave  (input  i_soft_rst, i_dly, output o_rst, o_done);
endinterface

// File: rtl/rst_seq_ctrl_sync.sv
// ----------------------------------------------------------------------------
// rst_sync_chain
// Reset-release synchronizer: a SYNC_STAGES-deep chain of flops that is
// cleared asynchronously by i_rst and shifts in a 1 on every clock edge.
//   clk       : clock
//   i_rst     : asynchronous active-high reset
//   o_rst_ok  : last flop of the chain; 1 once release has been synchronized
// ----------------------------------------------------------------------------
module rst_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_rst,
  output logic o_rst_ok
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_ok = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl
// Reset sequencer. All stage resets assert immediately with i_rst; release is
// synchronous, one stage at a time, with D+1 cycles between releases. A soft
// reset request in DONE replays the sequence.
//   clk    : clock
//   i_rst  : asynchronous active-high reset
//   bus    : rst_seq_ctrl_if.slave (i_soft_rst, i_dly in; o_rst, o_done out)
// ----------------------------------------------------------------------------
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_STAGES    = DEF_N_STAGES,
  parameter int DLY_W       = DEF_DLY_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         i_rst,
  rst_seq_ctrl_if.slave bus
);

  localparam int                  IDX_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] ALL_ONES = RST_VEC_ONES[N_STAGES-1:0];

  logic                w_rst_ok;

  state_t              r_state,  w_state_next;
  logic [DLY_W-1:0]    r_cnt,    w_cnt_next;
  logic [DLY_W-1:0]    r_dly_q,  w_dly_q_next;
  logic [IDX_W-1:0]    r_idx,    w_idx_next;
  logic [N_STAGES-1:0] r_rst,    w_rst_next;
  logic                r_done,   w_done_next;

  rst_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .i_rst    (i_rst),
    .o_rst_ok (w_rst_ok)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
      r_dly_q <= '0;
      r_idx   <= '0;
      r_rst   <= ALL_ONES;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_dly_q <= w_dly_q_next;
      r_idx   <= w_idx_next;
      r_rst   <= w_rst_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dly_q_next = r_dly_q;
    w_idx_next   = r_idx;
    w_rst_next   = r_rst;
    w_done_next  = r_done;

    case (r_state)
      ST_RST: begin
        w_rst_next  = ALL_ONES;
        w_done_next = 1'b0;
        if (w_rst_ok) begin
          w_dly_q_next = bus.i_dly;
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Equality compare on a DLY_W counter: D = max never wraps.
        if (r_cnt == r_dly_q) begin
          w_rst_next[r_idx] = 1'b0;
          w_cnt_next        = '0;
          if (r_idx == LAST_IDX) begin
            w_done_next  = 1'b1;
            w_state_next = ST_DONE;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_DONE: begin
        if (bus.i_soft_rst) begin
          w_rst_next   = ALL_ONES;
          w_done_next  = 1'b0;
          w_cnt_next   = '0;
          w_state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        w_rst_next = ALL_ONES;
        // Leaving HOLD goes through RST (rst_ok is already 1) so the new gap
        // is latched there and the replay restarts at S+D+2, one edge after
        // the hold count expires.
        if (r_cnt == r_dly_q) begin
          w_cnt_next   = '0;
          w_state_next = ST_RST;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = ST_RST;
      end
    endcase
  end

  assign bus.o_rst  = r_rst;
  assign bus.o_done = r_done;

endmodule
